cod_seq_ctrl: RTL and testbench

- Upstream symbol sequencer for the 14-segment code encoder (Cod_BHL).
- Generates the 3-bit symbol code on outputs A, B, C, which connect one-to-one to the encoder's A, B, C inputs.
- Code advances by one of three means: timed auto-advance, a debounced push-button step, or a synchronous parallel load.

---
 rtl/cod_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cod_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cod_seq_ctrl.sv
// cod_seq_ctrl: symbol sequencer that drives the A/B/C select inputs of the
// 14-segment code encoder.
//
// The 3-bit code advances in one of three ways:
//   - auto ticks from a dwell prescaler while run is high
//   - a debounced push-button step
//   - a synchronous parallel load
// When more than one source is active in a cycle, load wins over the button
// step, and the button step wins over the auto tick.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   run       in   1 = auto-advance enabled
//   dir       in   0 = step up (+1), 1 = step down (-1)
//   step_btn  in   raw asynchronous push-button, active high
//   load      in   one-cycle strobe, loads load_val
//   load_val  in   [2:0] value to load; bit2->A, bit1->B, bit0->C
//   A,B,C     out  code bits 2..0, registered
//   wrap      out  one-cycle pulse when the code crosses the 7/0 boundary
//
// Build option COD_SEQ_PINGPONG_EN: auto ticks ignore dir and bounce
// 0..7..0 using an internal direction flag. Button steps still follow dir
// and use modulo-8 arithmetic.
//
// Debounce FSM states:
//   state        | meaning
//   DB_IDLE      | button released, waiting for a synchronised high
//   DB_DEBOUNCE  | high seen, counting consecutive high cycles
//   DB_HELD      | step issued, waiting for release (one step per press)
module cod_seq_ctrl #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned DB_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       dir,
  input  logic       step_btn,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       wrap
);

  localparam int unsigned PW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    DB_IDLE     = 2'd0,
    DB_DEBOUNCE = 2'd1,
    DB_HELD     = 2'd2
  } db_state_e;

  logic [2:0]    code_q, code_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          s1_q, s2_q;
  db_state_e     db_state_q, db_state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          btn_step;
  logic          tick;
  logic [2:0]    code_up, code_dn;
`ifdef COD_SEQ_PINGPONG_EN
  logic          bounce_q, bounce_d;  // 0 = ticks go up, 1 = ticks go down
`endif

  assign code_up = code_q + 3'd1;
  assign code_dn = code_q - 3'd1;
  assign tick    = run && (presc_q == PRESC_LAST);

  // Debounce FSM; the step is issued combinationally on the final count
  // cycle so the code lands on the same edge the FSM enters DB_HELD.
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = db_cnt_q;
    btn_step   = 1'b0;
    case (db_state_q)
      DB_IDLE: begin
        if (s2_q) begin
          db_state_d = DB_DEBOUNCE;
          db_cnt_d   = '0;
        end
      end
      DB_DEBOUNCE: begin
        if (!s2_q) begin
          db_state_d = DB_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          btn_step   = 1'b1;
          db_state_d = DB_HELD;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      DB_HELD: begin
        if (!s2_q) db_state_d = DB_IDLE;
      end
      default: db_state_d = DB_IDLE;
    endcase
  end

  // Code update: load > button step > auto tick.
  always_comb begin
    code_d  = code_q;
    wrap_d  = 1'b0;
    presc_d = run ? (presc_q + PW'(1)) : '0;
`ifdef COD_SEQ_PINGPONG_EN
    bounce_d = bounce_q;
`endif
    if (tick) presc_d = '0;
    if (load) begin
      code_d  = load_val;
      presc_d = '0;
    end else if (btn_step) begin
      // A coincident tick is absorbed: the prescaler already restarts.
      if (dir) begin
        code_d = code_dn;
        wrap_d = (code_q == 3'd0);
      end else begin
        code_d = code_up;
        wrap_d = (code_q == 3'd7);
      end
    end else if (tick) begin
`ifdef COD_SEQ_PINGPONG_EN
      if (!bounce_q) begin
        code_d = code_up;
        if (code_up == 3'd7) begin
          bounce_d = 1'b1;
          wrap_d   = 1'b1;
        end
      end else begin
        code_d = code_dn;
        if (code_dn == 3'd0) begin
          bounce_d = 1'b0;
          wrap_d   = 1'b1;
        end
      end
`else
      if (dir) begin
        code_d = code_dn;
        wrap_d = (code_q == 3'd0);
      end else begin
        code_d = code_up;
        wrap_d = (code_q == 3'd7);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q     <= 3'd0;
      wrap_q     <= 1'b0;
      presc_q    <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_state_q <= DB_IDLE;
      db_cnt_q   <= '0;
`ifdef COD_SEQ_PINGPONG_EN
      bounce_q   <= 1'b0;
`endif
    end else begin
      code_q     <= code_d;
      wrap_q     <= wrap_d;
      presc_q    <= presc_d;
      s1_q       <= step_btn;
      s2_q       <= s1_q;
      db_state_q <= db_state_d;
      db_cnt_q   <= db_cnt_d;
`ifdef COD_SEQ_PINGPONG_EN
      bounce_q   <= bounce_d;
`endif
    end
  end

  assign A    = code_q[2];
  assign B    = code_q[1];
  assign C    = code_q[0];
  assign wrap = wrap_q;

endmodule

// File: tb/tb_cod_seq_ctrl.sv
// Directed testbench for cod_seq_ctrl with DWELL_CYCLES=8, DB_CYCLES=4.
// Expected codes follow the default build unless COD_SEQ_PINGPONG_EN is
// defined, in which case the auto-tick expectations switch to the bounce
// sequence.
module tb_cod_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       dir;
  logic       step_btn;
  logic       load;
  logic [2:0] load_val;
  logic       A, B, C, wrap;
  logic [2:0] code_o;

  int n_checks = 0;
  int n_errors = 0;

  assign code_o = {A, B, C};

  always #5 clk = ~clk;

  cod_seq_ctrl #(.DWELL_CYCLES(8), .DB_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .dir      (dir),
    .step_btn (step_btn),
    .load     (load),
    .load_val (load_val),
    .A        (A),
    .B        (B),
    .C        (C),
    .wrap     (wrap)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    run      = 1'b0;
    dir      = 1'b0;
    step_btn = 1'b0;
    load     = 1'b0;
    load_val = 3'd0;
    clk_edge();
    clk_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_code;
    apply_reset();
    load_val = 3'd5;
    load     = 1'b1;
    clk_edge();
    load = 1'b0;
    n_checks++;
    if (code_o !== 3'd5) begin
      n_errors++;
      $display("FAIL reset_preload: code=%b expected=101", code_o);
    end
    rst_n    = 1'b0;
    run      = 1'b1;
    step_btn = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      clk_edge();
      n_checks++;
      if (code_o !== 3'd0 || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold edge %0d: code=%b wrap=%b expected code=000 wrap=0", k, code_o, wrap);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      clk_edge();
      exp_code = (k == 7) ? 3'd1 : 3'd0;
      n_checks++;
      if (code_o !== exp_code || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_release edge %0d: code=%b wrap=%b expected code=%b wrap=0", k, code_o, wrap, exp_code);
      end
    end
    step_btn = 1'b0;
    run      = 1'b0;
  endtask

  task automatic test_auto_up();
    int n;
    logic [2:0] exp_code;
    logic exp_wrap;
    apply_reset();
    dir = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      clk_edge();
      n = k / 8;
`ifdef COD_SEQ_PINGPONG_EN
      exp_code = 3'((n <= 7) ? n : 14 - n);
      exp_wrap = (k == 56);
`else
      exp_code = 3'(n % 8);
      exp_wrap = (k == 64);
`endif
      n_checks++;
      if (code_o !== exp_code || wrap !== exp_wrap) begin
        n_errors++;
        $display("FAIL auto_up edge %0d: code=%b wrap=%b expected code=%b wrap=%b", k, code_o, wrap, exp_code, exp_wrap);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_debounce();
    logic [2:0] exp_code;
    apply_reset();
    run      = 1'b0;
    dir      = 1'b0;
    step_btn = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) step_btn = 1'b0;
      clk_edge();
      n_checks++;
      if (code_o !== 3'd0 || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL glitch edge %0d: code=%b wrap=%b expected code=000 wrap=0", k, code_o, wrap);
      end
    end
    step_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      clk_edge();
      exp_code = (k >= 7) ? 3'd1 : 3'd0;
      n_checks++;
      if (code_o !== exp_code || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL press_up edge %0d: code=%b wrap=%b expected code=%b wrap=0", k, code_o, wrap, exp_code);
      end
    end
    step_btn = 1'b0;
    for (int k = 1; k <= 10; k++) clk_edge();
    n_checks++;
    if (code_o !== 3'd1) begin
      n_errors++;
      $display("FAIL release_up: code=%b expected=001", code_o);
    end
    dir      = 1'b1;
    step_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      clk_edge();
      exp_code = (k >= 7) ? 3'd0 : 3'd1;
      n_checks++;
      if (code_o !== exp_code || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL press_down edge %0d: code=%b wrap=%b expected code=%b wrap=0", k, code_o, wrap, exp_code);
      end
    end
    step_btn = 1'b0;
    for (int k = 1; k <= 6; k++) clk_edge();
  endtask

  // Load, button step and auto tick all land on run edge 8.
  task automatic test_priority();
    logic [2:0] exp_code;
    apply_reset();
    run = 1'b1;
    dir = 1'b0;
    clk_edge();
    n_checks++;
    if (code_o !== 3'd0) begin
      n_errors++;
      $display("FAIL prio_start: code=%b expected=000", code_o);
    end
    step_btn = 1'b1;
    for (int r = 2; r <= 7; r++) begin
      clk_edge();
      n_checks++;
      if (code_o !== 3'd0) begin
        n_errors++;
        $display("FAIL prio_pre edge %0d: code=%b expected=000", r, code_o);
      end
    end
    load_val = 3'b101;
    load     = 1'b1;
    clk_edge();
    load = 1'b0;
    n_checks++;
    if (code_o !== 3'b101 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_load: code=%b wrap=%b expected code=101 wrap=0", code_o, wrap);
    end
    for (int r = 9; r <= 16; r++) begin
      clk_edge();
      exp_code = (r == 16) ? 3'b110 : 3'b101;
      n_checks++;
      if (code_o !== exp_code || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL prio_next_tick edge %0d: code=%b wrap=%b expected code=%b wrap=0", r, code_o, wrap, exp_code);
      end
    end
    run      = 1'b0;
    step_btn = 1'b0;
    for (int k = 1; k <= 4; k++) clk_edge();
  endtask

  task automatic test_down_wrap();
    logic [2:0] exp_code;
    logic exp_wrap;
    apply_reset();
    load_val = 3'd3;
    load     = 1'b1;
    clk_edge();
    load_val = 3'd0;
    clk_edge();
    load = 1'b0;
    n_checks++;
    if (code_o !== 3'd0) begin
      n_errors++;
      $display("FAIL dwrap_load: code=%b expected=000", code_o);
    end
    dir      = 1'b1;
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      clk_edge();
      exp_code = (k >= 7) ? 3'd7 : 3'd0;
      exp_wrap = (k == 7);
      n_checks++;
      if (code_o !== exp_code || wrap !== exp_wrap) begin
        n_errors++;
        $display("FAIL down_wrap edge %0d: code=%b wrap=%b expected code=%b wrap=%b", k, code_o, wrap, exp_code, exp_wrap);
      end
    end
    step_btn = 1'b0;
    for (int k = 1; k <= 4; k++) clk_edge();
  endtask

  // run=1, dir=1 for 16 ticks: modulo countdown, or bounce when enabled.
  task automatic test_dir_sweep();
    int n;
    logic [2:0] exp_code;
    logic exp_wrap;
    apply_reset();
    run = 1'b1;
    dir = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      clk_edge();
      n = k / 8;
`ifdef COD_SEQ_PINGPONG_EN
      exp_code = 3'((n <= 7) ? n : ((n <= 14) ? 14 - n : n - 14));
      exp_wrap = (k == 56) || (k == 112);
`else
      exp_code = 3'((8 - (n % 8)) % 8);
      exp_wrap = (k == 8) || (k == 72);
`endif
      n_checks++;
      if (code_o !== exp_code || wrap !== exp_wrap) begin
        n_errors++;
        $display("FAIL dir_sweep edge %0d: code=%b wrap=%b expected code=%b wrap=%b", k, code_o, wrap, exp_code, exp_wrap);
      end
    end
    run = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    run      = 1'b0;
    dir      = 1'b0;
    step_btn = 1'b0;
    load     = 1'b0;
    load_val = 3'd0;
    test_reset();
    test_auto_up();
    test_debounce();
    test_priority();
    test_down_wrap();
    test_dir_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
